// File: rtl/video_sync_receiver.sv
// rtl/video_sync_receiver.sv - measures, locks to and recovers coordinates from an incoming sync raster
// Ports: in_vga_clk/in_reset_n clock and sync active-low reset; in_h_sync/in_v_sync/in_blank_n raster in;
//        out_pixel_x/y/valid recovered coordinates; out_frame_start vsync-fall pulse; out_locked status;
//        out_sync_error lock-loss pulse; out_h_total/out_h_active/out_v_total/out_v_active measurements.
module video_sync_receiver #(
    parameter int lock_frames = 2,
    parameter int h_timeout   = 4095
) (
    input  logic        in_vga_clk,
    input  logic        in_reset_n,
    input  logic        in_h_sync,
    input  logic        in_v_sync,
    input  logic        in_blank_n,
    output logic [9:0]  out_pixel_x,
    output logic [9:0]  out_pixel_y,
    output logic        out_pixel_valid,
    output logic        out_frame_start,
    output logic        out_locked,
    output logic        out_sync_error,
    output logic [10:0] out_h_total,
    output logic [10:0] out_h_active,
    output logic [9:0]  out_v_total,
    output logic [9:0]  out_v_active
);
    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

    localparam logic [3:0]  LOCK_N = 4'(lock_frames);
    localparam logic [11:0] TO_N   = 12'(h_timeout);

    state_t      state_q, state_d;
    logic        s1_h_q, s1_v_q, s1_b_q, s2_h_q, s2_v_q, s2_b_q;
    logic [10:0] h_cnt_q, h_cnt_d, run_len_q, run_len_d;
    logic [11:0] idle_q, idle_d;
    logic [9:0]  line_cnt_q, line_cnt_d, run_cnt_q, run_cnt_d, y_cnt_q, y_cnt_d;
    logic [10:0] frame_h_q, frame_h_d, frame_r_q, frame_r_d;
    logic        fh_seen_q, fh_seen_d, fr_seen_q, fr_seen_d;
    logic        cons_q, cons_d, full_q, full_d, h_seen_q, h_seen_d;
    logic [10:0] ref_h_q, ref_h_d, ref_r_q, ref_r_d;
    logic [9:0]  ref_vt_q, ref_vt_d, ref_va_q, ref_va_d;
    logic        ref_valid_q, ref_valid_d;
    logic [3:0]  match_q, match_d;
    logic [9:0]  x_q, x_d, y_q, y_d, vt_q, vt_d, va_q, va_d;
    logic [10:0] ht_q, ht_d, ha_q, ha_d;
    logic        valid_q, fs_q, locked_q, locked_d, err_q, err_d;

    logic        hfall, vfall, bfall, timeout, frame_ok, frame_eq;
    logic [10:0] line_total, cur_r;

    // Edges are taken between stage 1 and its delayed copy, so every output is two clocks behind the pins.
    assign hfall      = s2_h_q & ~s1_h_q;
    assign vfall      = s2_v_q & ~s1_v_q;
    assign bfall      = s2_b_q & ~s1_b_q;
    assign line_total = (h_cnt_q == 11'h7FF) ? 11'h7FF : h_cnt_q + 11'd1;
    assign cur_r      = fr_seen_q ? frame_r_q : 11'd0;
    // A frame is only trustworthy if it began at a vsync fall and every line in it had a real predecessor.
    assign frame_ok   = full_q & fh_seen_q;
    assign frame_eq   = (frame_h_q == ref_h_q) && (cur_r == ref_r_q) &&
                        (line_cnt_q == ref_vt_q) && (run_cnt_q == ref_va_q);

    always_comb begin
        h_cnt_d    = hfall ? 11'd0 : ((h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1);
        idle_d     = hfall ? 12'd0 : ((idle_q == 12'hFFF) ? idle_q : idle_q + 12'd1);
        // Fires only on the cycle the idle count arrives at the limit, so a long dropout reports once.
        timeout    = (idle_d == TO_N) && (idle_q != TO_N);
        run_len_d  = run_len_q;
        if (s1_b_q) begin
            run_len_d = !s2_b_q ? 11'd1 : ((run_len_q == 11'h7FF) ? run_len_q : run_len_q + 11'd1);
        end
        // A sync/run edge coinciding with vsync fall belongs to the new frame.
        line_cnt_d = vfall ? {9'd0, hfall} : line_cnt_q + {9'd0, hfall};
        run_cnt_d  = vfall ? {9'd0, bfall} : run_cnt_q + {9'd0, bfall};
        y_cnt_d    = vfall ? 10'd0 : (bfall && y_cnt_q != 10'h3FF) ? y_cnt_q + 10'd1 : y_cnt_q;
        h_seen_d   = h_seen_q | hfall;

        fh_seen_d  = vfall ? 1'b0 : fh_seen_q;
        fr_seen_d  = vfall ? 1'b0 : fr_seen_q;
        cons_d     = vfall ? 1'b1 : cons_q;
        full_d     = vfall ? 1'b1 : full_q;
        frame_h_d  = frame_h_q;
        frame_r_d  = frame_r_q;
        if (hfall) begin
            if (!h_seen_q) full_d = 1'b0;
            if (!fh_seen_d) begin
                frame_h_d = line_total;
                fh_seen_d = 1'b1;
            end else if (line_total != frame_h_q) begin
                cons_d = 1'b0;
            end
        end
        if (bfall) begin
            if (!fr_seen_d) begin
                frame_r_d = run_len_q;
                fr_seen_d = 1'b1;
            end else if (run_len_q != frame_r_q) begin
                cons_d = 1'b0;
            end
        end
        if (timeout) full_d = 1'b0;

        ht_d = ht_q;
        ha_d = ha_q;
        vt_d = vt_q;
        va_d = va_q;
        if (vfall && frame_ok) begin
            ht_d = frame_h_q;
            ha_d = cur_r;
            vt_d = line_cnt_q;
            va_d = run_cnt_q;
        end

        x_d = (s1_b_q && s2_b_q) ? ((x_q == 10'h3FF) ? x_q : x_q + 10'd1) : 10'd0;
        y_d = s1_b_q ? y_cnt_d : 10'd0;
    end

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        ref_h_d     = ref_h_q;
        ref_r_d     = ref_r_q;
        ref_vt_d    = ref_vt_q;
        ref_va_d    = ref_va_q;
        ref_valid_d = ref_valid_q;
        err_d       = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vfall) begin
                    state_d     = ST_MEASURE;
                    match_d     = 4'd0;
                    ref_valid_d = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (vfall) begin
                    match_d     = (frame_ok && cons_q && ref_valid_q && frame_eq) ? match_q + 4'd1 : 4'd0;
                    ref_h_d     = frame_h_q;
                    ref_r_d     = cur_r;
                    ref_vt_d    = line_cnt_q;
                    ref_va_d    = run_cnt_q;
                    ref_valid_d = frame_ok;
                    if (match_d == LOCK_N) state_d = ST_LOCKED;
                end
            end
            default: begin
                if ((hfall && line_total != ref_h_q) || (bfall && run_len_q != ref_r_q)) begin
                    state_d = ST_MEASURE;
                    match_d = 4'd0;
                    err_d   = 1'b1;
                end
            end
        endcase
        // Timeout overrides any same-cycle mismatch and yields at most one error pulse.
        if (timeout) begin
            state_d     = ST_SEARCH;
            match_d     = 4'd0;
            ref_valid_d = 1'b0;
            err_d       = (state_q == ST_LOCKED);
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge in_vga_clk) begin
        if (!in_reset_n) begin
            state_q <= ST_SEARCH;
            {s1_h_q, s1_v_q, s1_b_q, s2_h_q, s2_v_q, s2_b_q} <= '0;
            h_cnt_q <= '0;     idle_q <= '0;      run_len_q <= '0;
            line_cnt_q <= '0;  run_cnt_q <= '0;   y_cnt_q <= '0;
            frame_h_q <= '0;   frame_r_q <= '0;   fh_seen_q <= 1'b0;
            fr_seen_q <= 1'b0; cons_q <= 1'b0;    full_q <= 1'b0;
            h_seen_q <= 1'b0;  ref_h_q <= '0;     ref_r_q <= '0;
            ref_vt_q <= '0;    ref_va_q <= '0;    ref_valid_q <= 1'b0;
            match_q <= '0;     x_q <= '0;         y_q <= '0;
            ht_q <= '0;        ha_q <= '0;        vt_q <= '0;
            va_q <= '0;        valid_q <= 1'b0;   fs_q <= 1'b0;
            locked_q <= 1'b0;  err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_h_q <= in_h_sync; s1_v_q <= in_v_sync; s1_b_q <= in_blank_n;
            s2_h_q <= s1_h_q;    s2_v_q <= s1_v_q;    s2_b_q <= s1_b_q;
            h_cnt_q <= h_cnt_d;       idle_q <= idle_d;       run_len_q <= run_len_d;
            line_cnt_q <= line_cnt_d; run_cnt_q <= run_cnt_d; y_cnt_q <= y_cnt_d;
            frame_h_q <= frame_h_d;   frame_r_q <= frame_r_d; fh_seen_q <= fh_seen_d;
            fr_seen_q <= fr_seen_d;   cons_q <= cons_d;       full_q <= full_d;
            h_seen_q <= h_seen_d;     ref_h_q <= ref_h_d;     ref_r_q <= ref_r_d;
            ref_vt_q <= ref_vt_d;     ref_va_q <= ref_va_d;   ref_valid_q <= ref_valid_d;
            match_q <= match_d;       x_q <= x_d;             y_q <= y_d;
            ht_q <= ht_d;             ha_q <= ha_d;           vt_q <= vt_d;
            va_q <= va_d;             valid_q <= s1_b_q;      fs_q <= vfall;
            locked_q <= locked_d;     err_q <= err_d;
        end
    end

    assign out_pixel_x     = x_q;
    assign out_pixel_y     = y_q;
    assign out_pixel_valid = valid_q;
    assign out_frame_start = fs_q;
    assign out_locked      = locked_q;
    assign out_sync_error  = err_q;
    assign out_h_total     = ht_q;
    assign out_h_active    = ha_q;
    assign out_v_total     = vt_q;
    assign out_v_active    = va_q;
endmodule

// File: tb/tb_video_sync_receiver.sv
// tb/tb_video_sync_receiver.sv - directed self-checking bench for video_sync_receiver
module tb_video_sync_receiver;
    logic        clk = 1'b0;
    logic        in_reset_n, in_h_sync, in_v_sync, in_blank_n;
    logic [9:0]  out_pixel_x, out_pixel_y, out_v_total, out_v_active;
    logic [10:0] out_h_total, out_h_active;
    logic        out_pixel_valid, out_frame_start, out_locked, out_sync_error;

    always #5 clk = ~clk;

    video_sync_receiver #(.lock_frames(2), .h_timeout(100)) dut (
        .in_vga_clk(clk), .in_reset_n(in_reset_n), .in_h_sync(in_h_sync),
        .in_v_sync(in_v_sync), .in_blank_n(in_blank_n),
        .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y),
        .out_pixel_valid(out_pixel_valid), .out_frame_start(out_frame_start),
        .out_locked(out_locked), .out_sync_error(out_sync_error),
        .out_h_total(out_h_total), .out_h_active(out_h_active),
        .out_v_total(out_v_total), .out_v_active(out_v_active)
    );

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    int g_ht, g_ha, g_hfp, g_hsw, g_vt, g_va, g_vfp, g_vsw;
    int hc, vc, bad_vc, g_vfalls;
    logic prev_v;

    always @(negedge clk) if (out_sync_error === 1'b1) err_pulses++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int ht, ha, hfp, hsw, vt, va, vfp, vsw);
        g_ht = ht; g_ha = ha; g_hfp = hfp; g_hsw = hsw;
        g_vt = vt; g_va = va; g_vfp = vfp; g_vsw = vsw;
        hc = 0; vc = 0;
    endtask

    task automatic gen_step();
        int line_len;
        line_len   = g_ht + ((vc == bad_vc) ? 1 : 0);
        in_blank_n = (hc < g_ha) && (vc < g_va);
        in_h_sync  = !((hc >= g_ha + g_hfp) && (hc < g_ha + g_hfp + g_hsw));
        in_v_sync  = !((vc >= g_va + g_vfp) && (vc < g_va + g_vfp + g_vsw));
        if (prev_v && !in_v_sync) g_vfalls++;
        prev_v = in_v_sync;
        hc++;
        if (hc == line_len) begin
            hc = 0;
            vc = (vc + 1 == g_vt) ? 0 : vc + 1;
        end
        clk_step();
    endtask

    task automatic run_to_vfall(input int n);
        int guard = 0;
        while (g_vfalls < n && guard < 20000) begin
            gen_step();
            guard++;
        end
        check_eq("vfall_reached", g_vfalls, n);
    endtask

    task automatic check_zero_outputs(input string ph);
        check_eq({ph, "_x"}, out_pixel_x, 0);
        check_eq({ph, "_y"}, out_pixel_y, 0);
        check_eq({ph, "_valid"}, out_pixel_valid, 0);
        check_eq({ph, "_fs"}, out_frame_start, 0);
        check_eq({ph, "_locked"}, out_locked, 0);
        check_eq({ph, "_err"}, out_sync_error, 0);
        check_eq({ph, "_ht"}, out_h_total, 0);
        check_eq({ph, "_ha"}, out_h_active, 0);
        check_eq({ph, "_vt"}, out_v_total, 0);
        check_eq({ph, "_va"}, out_v_active, 0);
    endtask

    task automatic check_meas(input string ph, input int ht, ha, vt, va);
        check_eq({ph, "_h_total"}, out_h_total, ht);
        check_eq({ph, "_h_active"}, out_h_active, ha);
        check_eq({ph, "_v_total"}, out_v_total, vt);
        check_eq({ph, "_v_active"}, out_v_active, va);
    endtask

    initial begin
        int base, e0, cnt, fx, fy, lx, ly, bad, guard;
        logic seen;
        in_reset_n = 1'b0; in_h_sync = 1'b1; in_v_sync = 1'b1; in_blank_n = 1'b0;
        bad_vc = -1; prev_v = 1'b1; g_vfalls = 0;
        repeat (3) clk_step();
        check_zero_outputs("rst");

        // Lock on raster A: 40 clk/line (24 active), 12 lines/frame (8 active)
        set_mode(40, 24, 4, 6, 12, 8, 1, 2);
        in_reset_n = 1'b1;
        run_to_vfall(4);
        check_eq("t1_prelock", out_locked, 0);
        gen_step();
        check_eq("t1_locked", out_locked, 1);
        check_eq("t1_frame_start", out_frame_start, 1);
        check_meas("t1", 40, 24, 12, 8);

        // One full frame: first/last active pixel and frame_start period
        cnt = 0; seen = 1'b0; bad = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        do begin
            gen_step();
            cnt++;
            if (out_pixel_valid) begin
                if (!seen) begin fx = out_pixel_x; fy = out_pixel_y; seen = 1'b1; end
                lx = out_pixel_x; ly = out_pixel_y;
            end else if (out_pixel_x != 0 || out_pixel_y != 0) begin
                bad++;
            end
        end while (!out_frame_start && cnt < 2000);
        check_eq("t2_fs_period", cnt, 480);
        check_eq("t2_first_x", fx, 0);
        check_eq("t2_first_y", fy, 0);
        check_eq("t2_last_x", lx, 23);
        check_eq("t2_last_y", ly, 7);
        check_eq("t2_zero_when_invalid", bad, 0);

        // One 41-clock line while locked
        e0 = err_pulses; base = g_vfalls; bad_vc = 2;
        guard = 0;
        while (vc != 4 && guard < 2000) begin gen_step(); guard++; end
        bad_vc = -1;
        run_to_vfall(base + 1);
        check_eq("t6_err_pulses", err_pulses - e0, 1);
        check_eq("t6_unlocked", out_locked, 0);
        run_to_vfall(base + 3);
        check_eq("t6_prelock", out_locked, 0);
        gen_step();
        check_eq("t6_relocked", out_locked, 1);
        check_eq("t6_err_total", err_pulses - e0, 1);

        // hsync dropout while locked, starting in horizontal blanking
        e0 = err_pulses; guard = 0;
        while (hc != g_ha + g_hfp + g_hsw && guard < 100) begin gen_step(); guard++; end
        in_h_sync = 1'b1; in_v_sync = 1'b1; in_blank_n = 1'b0; prev_v = 1'b1;
        repeat (130) clk_step();
        check_eq("t4_err_pulses", err_pulses - e0, 1);
        check_eq("t4_unlocked", out_locked, 0);
        check_meas("t4", 40, 24, 12, 8);

        // Mid-frame reset and relock
        set_mode(40, 24, 4, 6, 12, 8, 1, 2);
        guard = 0;
        while (vc != 3 && guard < 1000) begin gen_step(); guard++; end
        in_reset_n = 1'b0;
        gen_step();
        in_reset_n = 1'b1;
        check_zero_outputs("midrst");
        base = g_vfalls;
        run_to_vfall(base + 4);
        check_eq("t5_prelock", out_locked, 0);
        gen_step();
        check_eq("t5_locked", out_locked, 1);
        check_meas("t5", 40, 24, 12, 8);

        // Switch to raster B mid-frame: 32 clk/line (16 active), 10 lines (6 active)
        guard = 0;
        while (!(vc == 4 && hc == 10) && guard < 1000) begin gen_step(); guard++; end
        e0 = err_pulses; base = g_vfalls;
        set_mode(32, 16, 4, 6, 10, 6, 1, 2);
        run_to_vfall(base + 1);
        check_eq("t3_err_pulses", err_pulses - e0, 1);
        check_eq("t3_unlocked", out_locked, 0);
        run_to_vfall(base + 4);
        check_eq("t3_prelock", out_locked, 0);
        gen_step();
        check_eq("t3_relocked", out_locked, 1);
        check_meas("t3", 32, 16, 10, 6);
        check_eq("t3_err_total", err_pulses - e0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
